mem_port_arbiter: RTL and testbench

Shares the core's single external memory port between the instruction-fetch requester and the memory-access stage's load/store requester. It holds one outstanding transaction at a time and registers the request toward memory. Responses are routed back to the requester that owns the transaction. A timeout guards against a memory that never answers. It sits between the pipeline's fetch and memory-access stages and the external memory interface, and its ready/valid outputs drive the pipeline stall logic.

---
 rtl/mem_port_arbiter_if.sv | 63 ++++++
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - signal bundle between the pipeline, the arbiter and external memory
//
// Purpose: groups the fetch request/response, data request/response and
// external memory request/response signals of mem_port_arbiter.
// Modports:
//   slave  - the arbiter's view (takes requests, drives memory request and responses)
//   master - the surrounding pipeline + memory model's view (the mirror image)
// Signal groups:
//   if_*   fetch requester: req_valid/req_addr in, req_ready/resp_valid/resp_data out
//   flush  flush_if discards the current or outstanding fetch
//   d_*    load/store requester: valid/addr/write_enable/write_data/width in,
//          req_ready/resp_valid/resp_data out
//   mem_*  external memory: registered request fields out, req_ready/resp_valid/resp_data in
//   bus_error  timeout abort pulse

interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        flush_if;

  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_write_enable;
  logic [31:0] d_req_write_data;
  logic [2:0]  d_req_width;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;

  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_write_enable;
  logic [31:0] mem_req_write_data;
  logic [2:0]  mem_req_width;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  logic        bus_error;

  modport slave (
    input  if_req_valid, if_req_addr, flush_if,
    input  d_req_valid, d_req_addr, d_req_write_enable, d_req_write_data, d_req_width,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output if_req_ready, if_resp_valid, if_resp_data,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_write_enable, mem_req_write_data, mem_req_width,
    output bus_error
  );

  modport master (
    output if_req_valid, if_req_addr, flush_if,
    output d_req_valid, d_req_addr, d_req_write_enable, d_req_write_data, d_req_width,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  if_req_ready, if_resp_valid, if_resp_data,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_write_enable, mem_req_write_data, mem_req_width,
    input  bus_error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one external memory port between fetch and load/store
//
// Purpose: arbitrates between the instruction-fetch and load/store requesters,
// keeps a single transaction outstanding, registers the request toward memory,
// routes the response back to its owner and aborts a transaction that takes
// longer than TIMEOUT_CYCLES (0 disables the timeout).
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    mem_port_arbiter_if.slave: fetch port (if_*, flush_if), data port (d_*),
//          external memory port (mem_*) and the bus_error abort pulse

module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [31:0] TIMEOUT_LIM = TIMEOUT_CYCLES;
  localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [2:0]  FETCH_WIDTH = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // owner / last_grant: 0 = fetch, 1 = data
  logic        owner;
  logic        last_grant;
  logic        drop;
  logic [31:0] tmo_cnt;

  logic        fetch_elig;
  logic        grant_if;
  logic        grant_d;
  logic        busy;
  logic        resp_done;
  logic        tmo_hit;
  logic        fetch_dropped;

  logic        mem_req_valid_o;
  logic [31:0] mem_req_addr_q;
  logic        mem_req_we_q;
  logic [31:0] mem_req_wdata_q;
  logic [2:0]  mem_req_width_q;
  logic        if_resp_valid_q;
  logic [31:0] if_resp_data_q;
  logic        d_resp_valid_q;
  logic [31:0] d_resp_data_q;
  logic        bus_error_q;

  // Transaction events; none of these feed a mem_* output combinationally.
  assign busy          = (state == REQ) || (state == WAIT);
  assign resp_done     = (state == WAIT) && bus.mem_resp_valid;
  assign tmo_hit       = TIMEOUT_EN && busy && ((tmo_cnt + 32'd1) == TIMEOUT_LIM);
  // A flush arriving in the same cycle as the response still kills the fetch.
  assign fetch_dropped = drop || bus.flush_if;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_if || grant_d) state_next = REQ;
      end
      REQ: begin
        // An abort wins over a late acceptance so the counter bound is exact.
        if (tmo_hit)                state_next = IDLE;
        else if (bus.mem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (resp_done || tmo_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (arbitration and request valid)
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_elig      = 1'b0;
    grant_d         = 1'b0;
    grant_if        = 1'b0;
    mem_req_valid_o = 1'b0;
    // reset gates the grants so ready is 0 while reset is held.
    if (state == IDLE && reset) begin
      fetch_elig = bus.if_req_valid && !bus.flush_if;
      // Data wins unless it won last time and fetch is also eligible.
      grant_d    = bus.d_req_valid && (!fetch_elig || !last_grant);
      grant_if   = fetch_elig && !grant_d;
    end
    if (state == REQ) mem_req_valid_o = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Request latch, transaction bookkeeping and registered responses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner           <= 1'b0;
      last_grant      <= 1'b0;
      drop            <= 1'b0;
      tmo_cnt         <= 32'd0;
      mem_req_addr_q  <= 32'd0;
      mem_req_we_q    <= 1'b0;
      mem_req_wdata_q <= 32'd0;
      mem_req_width_q <= 3'd0;
      if_resp_valid_q <= 1'b0;
      if_resp_data_q  <= 32'd0;
      d_resp_valid_q  <= 1'b0;
      d_resp_data_q   <= 32'd0;
      bus_error_q     <= 1'b0;
    end else begin
      if_resp_valid_q <= 1'b0;
      d_resp_valid_q  <= 1'b0;
      bus_error_q     <= 1'b0;

      if (grant_d) begin
        mem_req_addr_q  <= bus.d_req_addr;
        mem_req_we_q    <= bus.d_req_write_enable;
        mem_req_wdata_q <= bus.d_req_write_data;
        mem_req_width_q <= bus.d_req_width;
      end else if (grant_if) begin
        mem_req_addr_q  <= bus.if_req_addr;
        mem_req_we_q    <= 1'b0;
        mem_req_wdata_q <= 32'd0;
        mem_req_width_q <= FETCH_WIDTH;
      end

      if (grant_d || grant_if) begin
        owner      <= grant_d;
        last_grant <= grant_d;
        drop       <= 1'b0;
        tmo_cnt    <= 32'd0;
      end

      if (busy) begin
        if (TIMEOUT_EN) tmo_cnt <= tmo_cnt + 32'd1;
        if (!owner && bus.flush_if) drop <= 1'b1;

        // A real response in the abort cycle is delivered rather than discarded.
        if (resp_done) begin
          if (owner) begin
            d_resp_valid_q <= 1'b1;
            d_resp_data_q  <= bus.mem_resp_data;
          end else if (!fetch_dropped) begin
            if_resp_valid_q <= 1'b1;
            if_resp_data_q  <= bus.mem_resp_data;
          end
        end else if (tmo_hit) begin
          // bus_error fires even when the fetch-side pulse is suppressed.
          bus_error_q <= 1'b1;
          if (owner) begin
            d_resp_valid_q <= 1'b1;
            d_resp_data_q  <= 32'd0;
          end else if (!fetch_dropped) begin
            if_resp_valid_q <= 1'b1;
            if_resp_data_q  <= 32'd0;
          end
        end
      end
    end
  end

  assign bus.if_req_ready         = grant_if;
  assign bus.d_req_ready          = grant_d;
  assign bus.mem_req_valid        = mem_req_valid_o;
  assign bus.mem_req_addr         = mem_req_addr_q;
  assign bus.mem_req_write_enable = mem_req_we_q;
  assign bus.mem_req_write_data   = mem_req_wdata_q;
  assign bus.mem_req_width        = mem_req_width_q;
  assign bus.if_resp_valid        = if_resp_valid_q;
  assign bus.if_resp_data         = if_resp_data_q;
  assign bus.d_resp_valid         = d_resp_valid_q;
  assign bus.d_resp_data          = d_resp_data_q;
  assign bus.bus_error            = bus_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus_t ();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_t.slave)
  );

  typedef struct {
    logic        rst;
    logic        if_v;
    logic [31:0] if_a;
    logic        fl;
    logic        d_v;
    logic [31:0] d_a;
    logic        d_we;
    logic [31:0] d_wd;
    logic [2:0]  d_w;
    logic        m_rdy;
    logic        m_rv;
    logic [31:0] m_rd;
    logic [137:0] exp_bits;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void add(
    input logic [31:0] rst, ifv, ifa, fl, dv, da, dwe, dwd, dw, mrdy, mrv, mrd,
    input logic [31:0] xifr, xdr, xmv, xma, xmwe, xmwd, xmw, xirv, xird, xdrv, xdrd, xbe);
    vec_t v;
    v.rst   = rst[0];
    v.if_v  = ifv[0];
    v.if_a  = ifa;
    v.fl    = fl[0];
    v.d_v   = dv[0];
    v.d_a   = da;
    v.d_we  = dwe[0];
    v.d_wd  = dwd;
    v.d_w   = dw[2:0];
    v.m_rdy = mrdy[0];
    v.m_rv  = mrv[0];
    v.m_rd  = mrd;
    v.exp_bits = {xifr[0], xdr[0], xmv[0], xma, xmwe[0], xmwd, xmw[2:0],
                  xirv[0], xird, xdrv[0], xdrd, xbe[0]};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tstep(input logic if_v, input logic [31:0] if_a, input logic fl,
                       input logic d_v, input logic [31:0] d_a,
                       input logic m_rdy, input logic m_rv, input logic [31:0] m_rd);
    @(negedge clk);
    bus_t.if_req_valid       = if_v;
    bus_t.if_req_addr        = if_a;
    bus_t.flush_if           = fl;
    bus_t.d_req_valid        = d_v;
    bus_t.d_req_addr         = d_a;
    bus_t.d_req_write_enable = 1'b0;
    bus_t.d_req_write_data   = 32'd0;
    bus_t.d_req_width        = 3'b010;
    bus_t.mem_req_ready      = m_rdy;
    bus_t.mem_resp_valid     = m_rv;
    bus_t.mem_resp_data      = m_rd;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [137:0] act;

    reset = 1'b0;
    {bus.if_req_valid, bus.if_req_addr, bus.flush_if} = '0;
    {bus.d_req_valid, bus.d_req_addr, bus.d_req_write_enable, bus.d_req_write_data, bus.d_req_width} = '0;
    {bus.mem_req_ready, bus.mem_resp_valid, bus.mem_resp_data} = '0;
    {bus_t.if_req_valid, bus_t.if_req_addr, bus_t.flush_if} = '0;
    {bus_t.d_req_valid, bus_t.d_req_addr, bus_t.d_req_write_enable, bus_t.d_req_write_data, bus_t.d_req_width} = '0;
    {bus_t.mem_req_ready, bus_t.mem_resp_valid, bus_t.mem_resp_data} = '0;

    // rst ifv ifa fl dv da dwe dwd dw mrdy mrv mrd | ifr dr mv ma mwe mwd mw irv ird drv drd be
    // reset gating, then single fetch of 0x100
    add(0,1,'h100,0,1,'h3000,0,0,0,0,0,0,  0,0,0,0,0,0,0,0,0,0,0,0);
    add(1,1,'h100,0,0,0,0,0,0,0,0,0,  1,0,0,0,0,0,0,0,0,0,0,0);
    add(1,0,'h100,0,0,0,0,0,0,1,0,0,  0,0,1,'h100,0,0,2,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,'h100,0,0,2,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,1,'h13,  0,0,0,'h100,0,0,2,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,'h100,0,0,2,1,'h13,0,0,0);
    // continuous contention: data, fetch, data, fetch
    add(1,1,'h200,0,1,'h3000,0,0,0,0,0,0,  0,1,0,'h100,0,0,2,0,'h13,0,0,0);
    add(1,1,'h200,0,1,'h3000,0,0,0,1,0,0,  0,0,1,'h3000,0,0,0,0,'h13,0,0,0);
    add(1,1,'h200,0,1,'h3000,0,0,0,0,1,'hAAAA0001,  0,0,0,'h3000,0,0,0,0,'h13,0,0,0);
    add(1,1,'h200,0,1,'h3000,0,0,0,0,0,0,  1,0,0,'h3000,0,0,0,0,'h13,1,'hAAAA0001,0);
    add(1,1,'h200,0,1,'h3000,0,0,0,1,0,0,  0,0,1,'h200,0,0,2,0,'h13,0,'hAAAA0001,0);
    add(1,1,'h200,0,1,'h3000,0,0,0,0,1,'h00500093,  0,0,0,'h200,0,0,2,0,'h13,0,'hAAAA0001,0);
    add(1,1,'h200,0,1,'h3000,0,0,0,0,0,0,  0,1,0,'h200,0,0,2,1,'h00500093,0,'hAAAA0001,0);
    add(1,1,'h200,0,1,'h3000,0,0,0,1,0,0,  0,0,1,'h3000,0,0,0,0,'h00500093,0,'hAAAA0001,0);
    add(1,1,'h200,0,1,'h3000,0,0,0,0,1,'hAAAA0002,  0,0,0,'h3000,0,0,0,0,'h00500093,0,'hAAAA0001,0);
    add(1,1,'h200,0,1,'h3000,0,0,0,0,0,0,  1,0,0,'h3000,0,0,0,0,'h00500093,1,'hAAAA0002,0);
    add(1,0,0,0,0,0,0,0,0,1,0,0,  0,0,1,'h200,0,0,2,0,'h00500093,0,'hAAAA0002,0);
    add(1,0,0,0,0,0,0,0,0,0,1,'h13,  0,0,0,'h200,0,0,2,0,'h00500093,0,'hAAAA0002,0);
    add(1,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,'h200,0,0,2,1,'h13,0,'hAAAA0002,0);
    // store 0xCAFEBABE to 0x2000, mem_req_ready held off 3 cycles
    add(1,0,0,0,1,'h2000,1,'hCAFEBABE,2,0,0,0,  0,1,0,'h200,0,0,2,0,'h13,0,'hAAAA0002,0);
    add(1,0,0,0,0,'hDEAD0000,0,'h12345678,0,0,0,0,  0,0,1,'h2000,1,'hCAFEBABE,2,0,'h13,0,'hAAAA0002,0);
    add(1,0,0,0,0,'hDEAD0000,0,'h12345678,0,0,0,0,  0,0,1,'h2000,1,'hCAFEBABE,2,0,'h13,0,'hAAAA0002,0);
    add(1,0,0,0,0,'hDEAD0000,0,'h12345678,0,0,0,0,  0,0,1,'h2000,1,'hCAFEBABE,2,0,'h13,0,'hAAAA0002,0);
    add(1,0,0,0,0,'hDEAD0000,0,'h12345678,0,1,0,0,  0,0,1,'h2000,1,'hCAFEBABE,2,0,'h13,0,'hAAAA0002,0);
    add(1,0,0,0,0,0,0,0,0,0,1,0,  0,0,0,'h2000,1,'hCAFEBABE,2,0,'h13,0,'hAAAA0002,0);
    add(1,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,'h2000,1,'hCAFEBABE,2,0,'h13,1,0,0);
    add(1,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,'h2000,1,'hCAFEBABE,2,0,'h13,0,0,0);
    // fetch flushed while waiting, then a normal load
    add(1,1,'h400,0,0,0,0,0,0,0,0,0,  1,0,0,'h2000,1,'hCAFEBABE,2,0,'h13,0,0,0);
    add(1,0,0,0,0,0,0,0,0,1,0,0,  0,0,1,'h400,0,0,2,0,'h13,0,0,0);
    add(1,0,0,1,0,0,0,0,0,0,0,0,  0,0,0,'h400,0,0,2,0,'h13,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,1,'h1234,  0,0,0,'h400,0,0,2,0,'h13,0,0,0);
    add(1,0,0,0,1,'h2004,0,0,2,0,0,0,  0,1,0,'h400,0,0,2,0,'h13,0,0,0);
    add(1,0,0,0,0,0,0,0,0,1,0,0,  0,0,1,'h2004,0,0,2,0,'h13,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,1,'h55667788,  0,0,0,'h2004,0,0,2,0,'h13,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,'h2004,0,0,2,0,'h13,1,'h55667788,0);
    // reset in WAIT, then data wins over a pending fetch
    add(1,1,'h500,0,0,0,0,0,0,0,0,0,  1,0,0,'h2004,0,0,2,0,'h13,0,'h55667788,0);
    add(1,0,0,0,0,0,0,0,0,1,0,0,  0,0,1,'h500,0,0,2,0,'h13,0,'h55667788,0);
    add(1,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,'h500,0,0,2,0,'h13,0,'h55667788,0);
    add(0,1,'h600,0,1,'h7000,0,0,2,0,0,0,  0,0,0,0,0,0,0,0,0,0,0,0);
    add(1,1,'h600,0,1,'h7000,0,0,2,0,0,0,  0,1,0,0,0,0,0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,1,0,0,  0,0,1,'h7000,0,0,2,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,1,'h0BADF00D,  0,0,0,'h7000,0,0,2,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,'h7000,0,0,2,0,0,1,'h0BADF00D,0);
    // stray response in IDLE, flushed fetch never granted
    add(1,0,0,0,0,0,0,0,0,0,1,'hFFFFFFFF,  0,0,0,'h7000,0,0,2,0,0,0,'h0BADF00D,0);
    add(1,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,'h7000,0,0,2,0,0,0,'h0BADF00D,0);
    add(1,1,'h800,1,0,0,0,0,0,0,0,0,  0,0,0,'h7000,0,0,2,0,0,0,'h0BADF00D,0);
    add(1,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,'h7000,0,0,2,0,0,0,'h0BADF00D,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset                  = vecs[i].rst;
      bus.if_req_valid       = vecs[i].if_v;
      bus.if_req_addr        = vecs[i].if_a;
      bus.flush_if           = vecs[i].fl;
      bus.d_req_valid        = vecs[i].d_v;
      bus.d_req_addr         = vecs[i].d_a;
      bus.d_req_write_enable = vecs[i].d_we;
      bus.d_req_write_data   = vecs[i].d_wd;
      bus.d_req_width        = vecs[i].d_w;
      bus.mem_req_ready      = vecs[i].m_rdy;
      bus.mem_resp_valid     = vecs[i].m_rv;
      bus.mem_resp_data      = vecs[i].m_rd;
      #1;
      act = {bus.if_req_ready, bus.d_req_ready, bus.mem_req_valid, bus.mem_req_addr,
             bus.mem_req_write_enable, bus.mem_req_write_data, bus.mem_req_width,
             bus.if_resp_valid, bus.if_resp_data, bus.d_resp_valid, bus.d_resp_data,
             bus.bus_error};
      check($sformatf("vec%0d", i), act, vecs[i].exp_bits);
    end

    // Timeout instance (TIMEOUT_CYCLES = 4): a normal load first so resp_data is nonzero.
    tstep(0, 0, 0, 1, 'h40, 0, 0, 0);
    check("t_load_grant", bus_t.d_req_ready, 1'b1);
    tstep(0, 0, 0, 0, 0, 1, 0, 0);
    tstep(0, 0, 0, 0, 0, 0, 1, 'h11112222);
    tstep(0, 0, 0, 0, 0, 0, 0, 0);
    check("t_load_resp", {bus_t.d_resp_valid, bus_t.d_resp_data, bus_t.bus_error}, {1'b1, 32'h11112222, 1'b0});

    // Load that never gets a response.
    tstep(0, 0, 0, 1, 'h44, 0, 0, 0);
    check("t_to_grant", bus_t.d_req_ready, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      tstep(0, 0, 0, 0, 0, (c == 1), 0, 0);
      check($sformatf("t_to_quiet_c%0d", c), {bus_t.d_resp_valid, bus_t.bus_error, bus_t.mem_req_valid},
            {2'b00, (c == 1)});
    end
    tstep(0, 0, 0, 0, 0, 0, 0, 0);
    check("t_to_abort", {bus_t.d_resp_valid, bus_t.d_resp_data, bus_t.bus_error}, {1'b1, 32'h0, 1'b1});
    tstep(0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF);
    check("t_to_after", {bus_t.d_resp_valid, bus_t.bus_error}, 2'b00);
    tstep(0, 0, 0, 0, 0, 0, 0, 0);
    check("t_late_ignored", {bus_t.d_resp_valid, bus_t.d_resp_data, bus_t.bus_error}, {1'b0, 32'h0, 1'b0});

    // Fetch flushed in REQ and then timing out: bus_error only.
    tstep(1, 'h80, 0, 0, 0, 0, 0, 0);
    check("t_f_grant", bus_t.if_req_ready, 1'b1);
    tstep(0, 0, 0, 0, 0, 0, 0, 0);
    tstep(0, 0, 1, 0, 0, 0, 0, 0);
    tstep(0, 0, 0, 0, 0, 0, 0, 0);
    tstep(0, 0, 0, 0, 0, 0, 0, 0);
    check("t_f_quiet_c4", {bus_t.if_resp_valid, bus_t.bus_error, bus_t.mem_req_valid}, 3'b001);
    tstep(0, 0, 0, 0, 0, 0, 0, 0);
    check("t_f_abort", {bus_t.if_resp_valid, bus_t.bus_error}, 2'b01);
    tstep(0, 0, 0, 0, 0, 0, 0, 0);
    check("t_f_after", {bus_t.if_resp_valid, bus_t.if_resp_data, bus_t.bus_error, bus_t.mem_req_valid},
          {1'b0, 32'h0, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
